sdf_fft_ctrl: RTL and testbench
===============================

SDF_FFT_CTRL -- requirements
Module: sdf_fft_ctrl

Interface
REQ-001 The block SHALL provide parameter N_POINTS, default 16, meaning FFT length; legal values are powers of two from 4 to 1024.
REQ-002 The block SHALL provide parameter STAGES, default $clog2(N_POINTS), meaning the number of cascaded butterfly stages sequenced.
REQ-003 The block SHALL provide derived localparam LAT = N_POINTS-1+STAGES, meaning the pipeline latency in advance cycles.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL provide port in_valid, input, 1 bit: an upstream sample is present.
REQ-007 The block SHALL provide port in_sof, input, 1 bit: the presented sample is index 0 of a frame.
REQ-008 The block SHALL provide port in_ready, output, 1 bit: the sample is accepted this cycle when high with in_valid.
REQ-009 The block SHALL provide port out_ready, input, 1 bit: downstream can take a result.
REQ-010 The block SHALL provide port stage_en, output, STAGES bits: the per-stage advance strobe; all bits are equal.
REQ-011 The block SHALL provide port stage_ctrl, output, STAGES bits: the control_bit of each butterfly stage (0 = fill, 1 = add/subtract).
REQ-012 The block SHALL provide port bubble, output, 1 bit: the advance carries zero data (drain); the datapath muxes its input to 0.
REQ-013 The block SHALL provide ports out_valid and out_sof, outputs, 1 bit each: the last-stage result is valid, and it is result index 0.
REQ-014 The block SHALL provide port sof_err, output, 1 bit: a one-cycle pulse on a framing violation.

Function
REQ-015 The block SHALL implement states IDLE, RUN and FLUSH; cnt_q is a $clog2(N_POINTS)-bit counter, drain_q counts up to LAT, and vshift is a LAT-deep shift register of {valid, sof} pairs.
REQ-016 The block SHALL assert adv = (in_valid & in_ready) | (state==FLUSH & out_ready & ~accept), and drive stage_en = {STAGES{adv}}.
REQ-017 The block SHALL drive in_ready = out_ready in IDLE and RUN; in FLUSH, in_ready = out_ready & (cnt_q==0).
REQ-018 The block SHALL drive stage_ctrl[s] as bit (STAGES-1-s) of ((cnt_q - s) mod N_POINTS), combinationally from cnt_q.
REQ-019 The block SHALL increment cnt_q by 1 mod N_POINTS on every adv, and SHALL hold cnt_q, vshift and drain_q whenever adv=0 (a full stall with no bubble inserted).
REQ-020 In IDLE, the block SHALL treat an accepted sample with in_sof=1 as index 0: cnt_q <= 1 and next state RUN.
REQ-021 In IDLE, the block SHALL drop an accepted sample with in_sof=0: adv stays 0 and sof_err pulses.
REQ-022 In RUN, the block SHALL treat an accepted in_sof=1 while cnt_q!=0 as ordinary data and pulse sof_err.
REQ-023 In RUN, the block SHALL go to FLUSH with drain_q <= LAT when the accepted sample has cnt_q==N_POINTS-1.
REQ-024 In RUN, if the next accepted sample after a wrap has in_sof=1, the block SHALL stay in RUN (back-to-back frames, no bubbles).
REQ-025 In FLUSH, the block SHALL assert bubble=1 on each non-input adv and decrement drain_q.
REQ-026 In FLUSH, an accepted in_sof=1 (only possible at cnt_q==0) SHALL return the block to RUN.
REQ-027 In FLUSH, the block SHALL return to IDLE when drain_q reaches 0 with no accept.
REQ-028 In FLUSH, an accepted in_valid with in_sof=0 SHALL pulse sof_err and be treated as a bubble.
REQ-029 On each adv, the block SHALL shift vshift, entering {accept, accept & in_sof & cnt_q==0}.
REQ-030 The block SHALL drive out_valid = adv & vshift_tail.valid and out_sof = adv & vshift_tail.sof; each frame SHALL yield exactly N_POINTS contiguous out_valid advances.
REQ-031 The block SHALL guarantee that output for input advance k appears at advance k+LAT, and that stalls add no other delay.

Reset
REQ-032 While rst=1 at a clk edge, the block SHALL set state=IDLE, cnt_q=0, drain_q=0 and vshift=0.
REQ-033 While rst=1, the block SHALL drive in_ready, stage_en, bubble, out_valid, out_sof and sof_err to 0.
REQ-034 The block SHALL discard a reset asserted mid-frame or mid-drain, including any in-flight valid flags.
REQ-035 After reset deasserts, the block SHALL produce no out_valid until a new sof frame is accepted.

Verification (N_POINTS=8, STAGES=3, LAT=10)
REQ-036 The bench SHALL cover: single frame with out_ready=1 and 8 contiguous valid samples with sof on the first -> stage_ctrl[0] = 0,0,0,0,1,1,1,1; 10 bubbles follow; out_valid high 8 cycles starting at advance 10, out_sof on the first; then IDLE.
REQ-037 The bench SHALL cover: two back-to-back frames of 16 samples -> no bubble between frames; out_valid contiguous for 16 advances; two out_sof pulses 8 apart.
REQ-038 The bench SHALL cover: out_ready=0 for 5 cycles mid-frame -> stage_en=0, in_ready=0, and cnt_q/stage_ctrl frozen; the result order is unchanged.
REQ-039 The bench SHALL cover: in IDLE, in_valid=1 with in_sof=0 -> sof_err pulse, stage_en stays 0, state stays IDLE.
REQ-040 The bench SHALL cover: new sof offered in FLUSH at cnt_q=3 -> in_ready=0 until cnt_q==0, then accepted; the previous frame's 8 outputs remain intact.
REQ-041 The bench SHALL cover: rst asserted at sample 5 -> all outputs 0 next cycle; no out_valid until a new frame fully fills.

Source files
------------

// File: rtl/sdf_fft_ctrl.sv
// sdf_fft_ctrl: sequencer for a single-path delay-feedback FFT pipeline.
// Tracks the sample index within a frame, drives the per-stage butterfly
// control bits, and inserts zero bubbles to drain the last frame. It also
// carries a {valid, sof} tag alongside the pipeline so that results leave
// the block exactly LAT advances after their input.
module sdf_fft_ctrl #(
    parameter int N_POINTS = 16,
    parameter int STAGES   = $clog2(N_POINTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              out_ready,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_ctrl,
    output logic              bubble,
    output logic              out_valid,
    output logic              out_sof,
    output logic              sof_err
);

    localparam int LAT = N_POINTS - 1 + STAGES;
    localparam int CW  = $clog2(N_POINTS);
    localparam int DW  = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(N_POINTS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   diff;
    logic [DW-1:0]   drain_q, drain_d;
    logic [LAT-1:0]  vs_valid_q;
    logic [LAT-1:0]  vs_sof_q;
    logic            rdy;
    logic            take;
    logic            accept;
    logic            adv;
    logic            err;

    // Handshake, advance and framing-error decode.
    // The counter is allowed to sit at any value while idle (the drain leaves
    // it wherever it stopped); idx treats it as 0 there, so an sof accepted
    // from idle is always index 0 without a separate counter clear.
    always_comb begin
        idx    = (state_q == IDLE) ? '0 : cnt_q;
        rdy    = out_ready & ((state_q != FLUSH) | (cnt_q == '0));
        take   = in_valid & rdy;
        accept = take & ((state_q == RUN) | in_sof);
        adv    = accept | ((state_q == FLUSH) & out_ready & ~accept);
        err    = 1'b0;
        case (state_q)
            IDLE:    err = take & ~in_sof;
            RUN:     err = take & in_sof;
            FLUSH:   err = take & ~in_sof;
            default: err = 1'b0;
        endcase
    end

    // Next-state and drain-count logic; only consumed on an advance.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                if (accept && cnt_q == LAST) begin
                    state_d = FLUSH;
                    drain_d = DW'(LAT);
                end
            end
            FLUSH: begin
                if (accept) begin
                    state_d = RUN;
                end else if (adv) begin
                    drain_d = (drain_q == '0) ? '0 : drain_q - 1'b1;
                    if (drain_q <= DW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Butterfly control: stage s sees the sample that entered s advances ago.
    always_comb begin
        stage_ctrl = '0;
        diff       = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            diff          = idx - CW'(s);
            stage_ctrl[s] = diff[STAGES-1-s];
        end
    end

    // Output drive; everything downstream-facing is held low during reset.
    always_comb begin
        in_ready  = rdy & ~rst;
        stage_en  = {STAGES{adv & ~rst}};
        bubble    = adv & ~accept & ~rst;
        out_valid = adv & vs_valid_q[LAT-1] & ~rst;
        out_sof   = adv & vs_sof_q[LAT-1] & ~rst;
        sof_err   = err & ~rst;
    end

    // State, index counter, drain counter and valid/sof tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            vs_valid_q <= '0;
            vs_sof_q   <= '0;
        end else begin
            state_q <= state_d;
            if (adv) begin
                cnt_q      <= idx + 1'b1;
                drain_q    <= drain_d;
                vs_valid_q <= {vs_valid_q[LAT-2:0], accept};
                vs_sof_q   <= {vs_sof_q[LAT-2:0], accept & in_sof & (idx == '0)};
            end
        end
    end

endmodule

// File: tb/tb_sdf_fft_ctrl.sv
// tb_sdf_fft_ctrl: directed bench for sdf_fft_ctrl at N_POINTS=8, STAGES=3.
module tb_sdf_fft_ctrl;

    localparam int N   = 8;
    localparam int ST  = 3;
    localparam int LOG = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic          out_ready;
    logic [ST-1:0] stage_en;
    logic [ST-1:0] stage_ctrl;
    logic          bubble;
    logic          out_valid;
    logic          out_sof;
    logic          sof_err;

    int n_cmp = 0;
    int n_err = 0;

    // Per-advance log of the DUT's outputs, plus running event counters.
    logic log_b [0:LOG-1];
    logic log_v [0:LOG-1];
    logic log_s [0:LOG-1];
    int   a       = 0;
    int   err_cnt = 0;
    int   stray   = 0;

    // stage_ctrl {s2,s1,s0} for sample index 0..7, worked out by hand.
    int sc_tab [0:7] = '{2, 4, 0, 6, 3, 5, 1, 7};

    sdf_fft_ctrl #(
        .N_POINTS(N),
        .STAGES  (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .stage_en  (stage_en),
        .stage_ctrl(stage_ctrl),
        .bubble    (bubble),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    // Record outputs on every advance, mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (stage_en[0]) begin
                if (a < LOG) begin
                    log_b[a] = bubble;
                    log_v[a] = out_valid;
                    log_s[a] = out_sof;
                end
                a++;
            end
            if ((stage_en != {ST{stage_en[0]}}) || (out_valid & ~stage_en[0]) ||
                (out_sof & ~out_valid) || (bubble & ~stage_en[0]))
                stray++;
            if (sof_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic s, input logic r);
        in_valid  = v;
        in_sof    = s;
        out_ready = r;
    endtask

    task automatic idle(input int n);
        drv(1'b0, 1'b0, 1'b1);
        repeat (n) fin();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        drv(1'b1, 1'b1, 1'b1);
        half();
        check({tag, "_rst_out"}, {in_ready, stage_en, bubble, out_valid, out_sof, sof_err}, 0);
        fin();
        fin();
        rst = 1'b0;
        drv(1'b0, 1'b0, 1'b1);
        fin();
    endtask

    // One contiguous 8-sample frame with sof on the first sample.
    task automatic frame(input string tag);
        for (int i = 0; i < N; i++) begin
            drv(1'b1, i == 0, 1'b1);
            half();
            check({tag, "_rdy"}, in_ready, 1);
            check({tag, "_sc"}, stage_ctrl, sc_tab[i]);
            fin();
        end
    endtask

    // Compare the logged advance window against expected bit masks.
    task automatic stream(input string tag, input int base, input int n,
                          input logic [63:0] eb, input logic [63:0] ev, input logic [63:0] es);
        logic [63:0] gb = '0;
        logic [63:0] gv = '0;
        logic [63:0] gs = '0;
        check({tag, "_nadv"}, a - base, n);
        for (int k = 0; k < n && k < 64; k++) begin
            if (base + k < LOG) begin
                gb[k] = log_b[base + k];
                gv[k] = log_v[base + k];
                gs[k] = log_s[base + k];
            end
        end
        check({tag, "_bubble"}, gb, eb);
        check({tag, "_ovalid"}, gv, ev);
        check({tag, "_osof"}, gs, es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int e0;
        drv(1'b0, 1'b0, 1'b1);
        fin();
        fin();

        // Two single frames separated by idle, no reset between them.
        do_reset("t1");
        base = a;
        e0   = err_cnt;
        frame("t1a");
        idle(15);
        drv(1'b0, 1'b0, 1'b1);
        half();
        check("t1_idle_rdy", {in_ready, stage_en}, 4'b1000);
        fin();
        frame("t1b");
        idle(15);
        stream("t1", base, 36, rng(8, 17) | rng(26, 35), rng(10, 17) | rng(28, 35),
               rng(10, 10) | rng(28, 28));
        check("t1_nerr", err_cnt - e0, 0);

        // Back-to-back frames: no bubble between them.
        do_reset("t2");
        base = a;
        e0   = err_cnt;
        for (int i = 0; i < 2 * N; i++) begin
            drv(1'b1, (i % N) == 0, 1'b1);
            half();
            check("t2_rdy", in_ready, 1);
            check("t2_sc", stage_ctrl, sc_tab[i % N]);
            fin();
        end
        idle(15);
        stream("t2", base, 26, rng(16, 25), rng(10, 25), rng(10, 10) | rng(18, 18));
        check("t2_nerr", err_cnt - e0, 0);

        // Downstream stall for 5 cycles before sample 3.
        do_reset("t3");
        base = a;
        for (int i = 0; i < N; i++) begin
            if (i == 3) begin
                repeat (5) begin
                    drv(1'b1, 1'b0, 1'b0);
                    half();
                    check("t3_stall", {stage_en, in_ready}, 0);
                    check("t3_frozen_sc", stage_ctrl, 6);
                    fin();
                end
            end
            drv(1'b1, i == 0, 1'b1);
            half();
            check("t3_sc", stage_ctrl, sc_tab[i]);
            fin();
        end
        idle(15);
        stream("t3", base, 18, rng(8, 17), rng(10, 17), rng(10, 10));

        // Non-sof sample offered while idle is dropped.
        do_reset("t4");
        base = a;
        e0   = err_cnt;
        drv(1'b1, 1'b0, 1'b1);
        half();
        check("t4_err", sof_err, 1);
        check("t4_en", stage_en, 0);
        fin();
        repeat (3) begin
            drv(1'b0, 1'b0, 1'b1);
            half();
            check("t4_quiet", {stage_en, sof_err}, 0);
            fin();
        end
        check("t4_nerr", err_cnt - e0, 1);
        frame("t4");
        idle(15);
        stream("t4", base, 18, rng(8, 17), rng(10, 17), rng(10, 10));
        check("t4_nerr_end", err_cnt - e0, 1);

        // New sof offered during drain at index 3; held off until index 0.
        do_reset("t5");
        base = a;
        e0   = err_cnt;
        frame("t5a");
        idle(3);
        repeat (5) begin
            drv(1'b1, 1'b1, 1'b1);
            half();
            check("t5_hold", {in_ready, bubble}, 2'b01);
            fin();
        end
        frame("t5b");
        idle(15);
        stream("t5", base, 34, rng(8, 15) | rng(24, 33), rng(10, 17) | rng(26, 33),
               rng(10, 10) | rng(26, 26));
        check("t5_nerr", err_cnt - e0, 0);

        // Reset mid-frame at sample 5 discards everything in flight.
        do_reset("t6");
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, i == 0, 1'b1);
            fin();
        end
        rst = 1'b1;
        drv(1'b1, 1'b0, 1'b1);
        half();
        check("t6_rst_out", {in_ready, stage_en, bubble, out_valid, out_sof, sof_err}, 0);
        fin();
        rst = 1'b0;
        base = a;
        idle(20);
        check("t6_quiet_nadv", a - base, 0);
        base = a;
        frame("t6");
        idle(15);
        stream("t6", base, 18, rng(8, 17), rng(10, 17), rng(10, 10));

        check("stray_outputs", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
